// File: rtl/keys_debounce.sv
// keys_debounce: per-key 2-flop synchronizer + consecutive-mismatch debouncer on a shared tick.
// Optional one-cycle change strobe keys_changed_o when NYAN_KEYS_CHANGE_FLAG_EN is defined.
module keys_debounce_lane #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic clk_g_i,
  input  logic rstn_g_i,
  input  logic i_raw,
  input  logic i_tick,
`ifdef NYAN_KEYS_CHANGE_FLAG_EN
  output logic o_acc,
`endif
  output logic o_key
);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CNT - 1);

  logic          r_s1, r_s2;
  logic [DW-1:0] r_dcnt;
  logic          w_diff, w_acc;

  assign w_diff = r_s2 ^ o_key;
  // Accept on the DEBOUNCE_CNT-th consecutive mismatching tick.
  assign w_acc  = i_tick & w_diff & (r_dcnt == DMAX);

`ifdef NYAN_KEYS_CHANGE_FLAG_EN
  assign o_acc = w_acc;
`endif

  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_dcnt <= '0;
      o_key  <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (i_tick) begin
        if (!w_diff || w_acc) r_dcnt <= '0;
        else                  r_dcnt <= r_dcnt + DW'(1);
        if (w_acc) o_key <= r_s2;
      end
    end
  end
endmodule

module keys_debounce #(
  parameter int NUM_KEYS     = 89,
  parameter int TICK_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                clk_g_i,
  input  logic                rstn_g_i,
  input  logic [NUM_KEYS-1:0] keys_raw_i_g,
`ifdef NYAN_KEYS_CHANGE_FLAG_EN
  output logic                keys_changed_o,
`endif
  output logic [NUM_KEYS-1:0] keys_o_g
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = (r_cnt == CMAX);

  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) r_cnt <= '0;
    else           r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
  end

`ifdef NYAN_KEYS_CHANGE_FLAG_EN
  logic [NUM_KEYS-1:0] w_acc;
`endif

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    keys_debounce_lane #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_lane (
      .clk_g_i  (clk_g_i),
      .rstn_g_i (rstn_g_i),
      .i_raw    (keys_raw_i_g[g]),
      .i_tick   (w_tick),
`ifdef NYAN_KEYS_CHANGE_FLAG_EN
      .o_acc    (w_acc[g]),
`endif
      .o_key    (keys_o_g[g])
    );
  end

`ifdef NYAN_KEYS_CHANGE_FLAG_EN
  // Any lane accepting on this tick edge means keys_o_g changes on it.
  always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
    if (!rstn_g_i) keys_changed_o <= 1'b0;
    else           keys_changed_o <= |w_acc;
  end
`endif
endmodule

// File: doc/keys_debounce.md
# keys_debounce

Per-key synchronizer and debouncer for the keyboard's raw switch inputs, sitting directly upstream of `spi_keys`. It samples `NUM_KEYS` asynchronous switch lines on a shared prescaled tick and drives a clean, registered key-state vector. That vector connects straight to `spi_keys.keys_i_g`, so the SPI host only ever reads settled states. Each key uses a saturating-free consecutive-mismatch integrator; there is no per-key timer.

## Interface
- `NUM_KEYS`, 89, number of key lines; must match `spi_keys`.
- `TICK_DIV`, 1000, `clk_g_i` cycles per sample tick; minimum 2.
- `DEBOUNCE_CNT`, 4, consecutive mismatching ticks needed to accept a new key state; minimum 1.

Ports:
- `clk_g_i`  in  1  system clock; the only clock.
- `rstn_g_i`  in  1  reset, asynchronous, active-low.
- `keys_raw_i_g`  in  NUM_KEYS  raw switch lines, asynchronous to `clk_g_i`; 1 = pressed.
- `keys_o_g`  out  NUM_KEYS  debounced key state, registered; 1 = pressed; connects to `spi_keys.keys_i_g`.
- `keys_changed_o`  out  1  one-cycle change strobe; only present with `NYAN_KEYS_CHANGE_FLAG_EN`.

## Operation
- **Synchronizer:** two flops per key (`s1`, `s2`) on `clk_g_i`. All later logic uses `s2` only.
- **Prescaler:**
  - `cnt`, width `$clog2(TICK_DIV)`, resets to 0.
  - Each cycle: `cnt <= (cnt == TICK_DIV-1) ? 0 : cnt+1`.
  - `tick = (cnt == TICK_DIV-1)`, combinational.
- **Per-key integrator `dcnt[k]`:** width `$clog2(DEBOUNCE_CNT+1)`, resets to 0. Updated only on edges where `tick` = 1:
  - If `s2[k] == keys_o_g[k]`: `dcnt[k] <= 0`.
  - Else, if `dcnt[k] == DEBOUNCE_CNT-1`: `keys_o_g[k] <= s2[k]` and `dcnt[k] <= 0`.
  - Else: `dcnt[k] <= dcnt[k]+1`.
- Any matching tick clears the integrator, so mismatching ticks must be consecutive.
- Keys are fully independent. Several keys may toggle on the same tick.
- No wrap-around is possible: the integrator clears on acceptance and never exceeds `DEBOUNCE_CNT-1`.
- With `DEBOUNCE_CNT` = 1, a state is accepted on the first mismatching tick.

## Timing
- **Reset values:** `keys_o_g` = 0, `keys_changed_o` = 0, `s1` = `s2` = 0, `cnt` = 0, all `dcnt` = 0.
- Reset is asynchronous in both assertion and removal paths. Reset asserted mid-operation clears everything immediately, including partially counted keys.
- Edge numbering: edge 1 is the first rising edge with `rstn_g_i` high. The first tick edge is edge `TICK_DIV`, then every `TICK_DIV` cycles after that.
- A raw change set up before edge n reaches `s2` after edge n+1.
- **Latency:** if the change is held stable, `keys_o_g` updates at the `DEBOUNCE_CNT`-th tick edge whose `s2` value differs from `keys_o_g`. Worst case is `2 + DEBOUNCE_CNT*TICK_DIV` cycles.
- **Glitch rejection:** a pulse shorter than `(DEBOUNCE_CNT-1)*TICK_DIV` cycles can never be accepted.

## Configuration
- **`NYAN_KEYS_CHANGE_FLAG_EN` defined:**
  - `keys_changed_o` is present and registered.
  - It is high for exactly the one cycle after any tick edge on which at least one `keys_o_g` bit changed.
  - Otherwise it is 0.
- **Macro undefined:** the port and its logic are absent. `keys_o_g` behaviour is identical in both builds.

## Test plan
All scenarios use `NUM_KEYS`=8, `TICK_DIV`=4, `DEBOUNCE_CNT`=3, so tick edges are 4, 8, 12, …
- **Stable press:** `keys_raw_i_g` = 8'h01 before edge 1, held.
  - `keys_o_g` = 8'h00 through edge 11 and 8'h01 after edge 12.
  - With the macro, `keys_changed_o` = 1 for the cycle after edge 12 only.
- **Glitch:** `keys_raw_i_g[3]` high for 5 cycles from edge 1, then low.
  - `keys_o_g` stays 8'h00 for 40 cycles; `keys_changed_o` is never asserted.
- **Release:** from `keys_o_g` = 8'h01, set `keys_raw_i_g` = 8'h00 held.
  - `keys_o_g` returns to 8'h00 exactly 3 ticks after `s2` drops.
- **Bounce restart:** key 2 high; drop to low for one full tick period after the 2nd matching tick; then high again.
  - The integrator restarts, and acceptance happens 3 ticks after the final rise, not earlier.
- **Simultaneous keys:** `keys_raw_i_g` = 8'hA5 before edge 1.
  - `keys_o_g` = 8'hA5 after edge 12 in a single update.
  - With the macro, exactly one `keys_changed_o` pulse.
- **Reset mid-count:** press key 0; assert `rstn_g_i` = 0 asynchronously between edges 9 and 10.
  - `keys_o_g` = 0 immediately and `cnt` = 0.
  - After release with key 0 still held, acceptance occurs at the new edge 12.
